// File: rtl/branch_unit_if.sv
// branch_unit_if: decode-to-branch-unit request handshake.
interface branch_unit_if #(parameter int ADDR_WIDTH = 11);
   logic br_valid;
   logic [2:0] br_op;
   logic [ADDR_WIDTH-1:0] br_target;
   logic br_ready;
   modport master(output br_valid, br_op, br_target, input br_ready);
   modport slave(input br_valid, br_op, br_target, output br_ready);
endinterface

// File: rtl/branch_unit.sv
// branch_unit: PC sequencing, Z/N branch resolution with flag-hazard stall,
// post-branch fetch flush and a CALL/RET return-address stack.
module branch_unit #(
   parameter int ADDR_WIDTH = 11,
   parameter int STACK_DEPTH = 4,
   parameter int FLUSH_CYCLES = 1
) (
   input logic clock,
   input logic branch_reset_n,
   input logic flag_Z,
   input logic flag_N,
   input logic status_wr,
   input logic pc_inc,
   branch_unit_if.slave br,
   output logic [ADDR_WIDTH-1:0] pc_out,
   output logic taken,
   output logic stack_err
);
   localparam int PW = $clog2(STACK_DEPTH);
   localparam int CW = $clog2(FLUSH_CYCLES + 1);
   typedef enum logic {IDLE, FLUSH} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [ADDR_WIDTH-1:0] stk [STACK_DEPTH];
   logic [PW:0] sp;
   logic [PW-1:0] top;
   logic full, empty, cond_op, hazard, cond, accept, tk, is_call, is_ret;
   logic [ADDR_WIDTH-1:0] pc_seq, pc_nx;
   always_comb begin
      pc_seq = pc_out + ADDR_WIDTH'(1);
      full = sp == (PW+1)'(STACK_DEPTH);
      empty = sp == '0;
      top = PW'(sp - (PW+1)'(1));
      is_call = br.br_op == 3'd5;
      is_ret = br.br_op == 3'd6;
      cond_op = br.br_op != 3'd0 && br.br_op < 3'd5;
      // a flag write this cycle makes the current flags stale for conditional ops
      hazard = br.br_valid && cond_op && status_wr;
      cond = br.br_op == 3'd0 ? 1'b1 :
             br.br_op == 3'd1 ? flag_Z :
             br.br_op == 3'd2 ? !flag_Z :
             br.br_op == 3'd3 ? flag_N :
             br.br_op == 3'd4 ? !flag_N && !flag_Z :
             is_call ? !full :
             is_ret ? !empty : 1'b0;
      accept = br.br_valid && br.br_ready;
      tk = accept && cond;
      pc_nx = accept ? (tk ? (is_ret ? stk[top] : br.br_target) : pc_seq) :
              (pc_inc && state == IDLE ? pc_seq : pc_out);
   end
   always_ff @(posedge clock or negedge branch_reset_n)
      if (!branch_reset_n) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = state == IDLE ? (tk ? FLUSH : IDLE) : (cnt == CW'(1) ? IDLE : FLUSH);
   always_comb
      br.br_ready = branch_reset_n && state == IDLE && !hazard;
   always_ff @(posedge clock or negedge branch_reset_n)
      if (!branch_reset_n) begin
         pc_out <= '0;
         taken <= 1'b0;
         stack_err <= 1'b0;
         cnt <= '0;
         sp <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) stk[i] <= '0;
      end else begin
         pc_out <= pc_nx;
         taken <= tk;
         cnt <= tk ? CW'(FLUSH_CYCLES) : (state == FLUSH ? cnt - CW'(1) : cnt);
         if (accept && !tk && (is_call || is_ret)) stack_err <= 1'b1;
         if (tk && is_call) begin
            stk[sp[PW-1:0]] <= pc_seq;
            sp <= sp + (PW+1)'(1);
         end else if (tk && is_ret) sp <= sp - (PW+1)'(1);
      end
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed and random stimulus against a queue-based reference model.
module tb_branch_unit;
   localparam int AW = 11, DEPTH = 4, FLUSH_N = 1, MODN = 2048;
   logic clock = 0, branch_reset_n = 0, flag_Z = 0, flag_N = 0, status_wr = 0, pc_inc = 0;
   logic [AW-1:0] pc_out;
   logic taken, stack_err;
   int compared = 0, mismatched = 0;
   int m_pc, m_flush;
   int m_stack[$];
   bit m_taken, m_err;
   branch_unit_if #(.ADDR_WIDTH(AW)) bi ();
   branch_unit #(.ADDR_WIDTH(AW), .STACK_DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_N)) dut (
      .clock(clock), .branch_reset_n(branch_reset_n), .flag_Z(flag_Z), .flag_N(flag_N),
      .status_wr(status_wr), .pc_inc(pc_inc), .br(bi.slave),
      .pc_out(pc_out), .taken(taken), .stack_err(stack_err));
   always #5 clock = ~clock;
   task automatic chk(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // call just after a rising edge: asserts reset mid-cycle and releases at the next falling edge
   task automatic do_reset();
      #1 branch_reset_n = 0;
      bi.br_valid = 1;
      bi.br_op = 3'd0;
      #1;
      chk("rst_pc", pc_out, 0);
      chk("rst_taken", taken, 0);
      chk("rst_err", stack_err, 0);
      chk("rst_ready", bi.br_ready, 0);
      m_pc = 0; m_flush = 0; m_taken = 0; m_err = 0;
      m_stack.delete();
      @(negedge clock);
      branch_reset_n = 1;
      bi.br_valid = 0;
      pc_inc = 0;
      status_wr = 0;
   endtask
   task automatic step(input bit v, input int op, input int tgt, input bit inc,
                       input bit swr, input bit nz, input bit nn);
      bit rdy, tk;
      @(negedge clock);
      bi.br_valid = v;
      bi.br_op = 3'(op);
      bi.br_target = AW'(tgt);
      pc_inc = inc;
      status_wr = swr;
      #1;
      rdy = m_flush == 0 && !(v && op >= 1 && op <= 4 && swr);
      chk("ready", bi.br_ready, rdy);
      if (v && rdy) begin
         case (op)
            0: tk = 1;
            1: tk = flag_Z;
            2: tk = !flag_Z;
            3: tk = flag_N;
            4: tk = !flag_N && !flag_Z;
            5: tk = m_stack.size() < DEPTH;
            6: tk = m_stack.size() > 0;
            default: tk = 0;
         endcase
         if (tk) begin
            if (op == 5) m_stack.push_back((m_pc + 1) % MODN);
            m_pc = op == 6 ? m_stack.pop_back() : tgt;
            m_flush = FLUSH_N;
         end else begin
            m_pc = (m_pc + 1) % MODN;
            if (op == 5 || op == 6) m_err = 1;
         end
         m_taken = tk;
      end else begin
         m_taken = 0;
         if (m_flush > 0) m_flush--;
         else if (inc) m_pc = (m_pc + 1) % MODN;
      end
      @(posedge clock);
      #1;
      if (swr) begin flag_Z = nz; flag_N = nn; end
      chk("pc", pc_out, m_pc);
      chk("taken", taken, m_taken);
      chk("stack_err", stack_err, m_err);
   endtask
   task automatic idle(input bit inc);
      step(0, 0, 0, inc, 0, flag_Z, flag_N);
   endtask
   initial begin
      bi.br_valid = 0; bi.br_op = 0; bi.br_target = 0;
      @(posedge clock);
      do_reset();
      repeat (3) idle(1);
      chk("inc3", pc_out, 3);
      step(1, 0, 'h010, 0, 0, 0, 0);
      idle(0);
      flag_Z = 1;
      step(1, 1, 'h123, 0, 0, 0, 0);
      chk("bz_taken_pc", pc_out, 'h123);
      idle(1);
      step(1, 0, 'h010, 0, 0, 0, 0);
      idle(0);
      flag_Z = 0;
      step(1, 1, 'h123, 0, 0, 0, 0);
      chk("bz_not_pc", pc_out, 'h011);
      step(1, 3, 'h3A0, 0, 1, 0, 1);
      step(1, 3, 'h3A0, 0, 0, 0, 0);
      chk("hazard_pc", pc_out, 'h3A0);
      idle(0);
      step(1, 0, 'h040, 0, 0, 0, 0);
      idle(0);
      step(1, 5, 'h200, 0, 0, 0, 0);
      chk("call_pc", pc_out, 'h200);
      idle(0);
      step(1, 6, 0, 0, 0, 0, 0);
      chk("ret_pc", pc_out, 'h041);
      idle(0);
      for (int i = 0; i < 4; i++) begin
         step(1, 5, 'h100 + 16 * i, 0, 0, 0, 0);
         idle(0);
      end
      step(1, 5, 'h500, 0, 0, 0, 0);
      chk("ovf_err", stack_err, 1);
      for (int i = 0; i < 4; i++) begin
         step(1, 6, 0, 0, 0, 0, 0);
         idle(1);
      end
      step(1, 6, 0, 0, 0, 0, 0);
      chk("unf_err", stack_err, 1);
      step(1, 0, 'h7FF, 0, 0, 0, 0);
      idle(1);
      idle(1);
      chk("wrap_pc", pc_out, 0);
      step(1, 0, 'h055, 1, 0, 0, 0);
      chk("prio_pc", pc_out, 'h055);
      do_reset();
      step(1, 0, 'h2AA, 0, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 7),
              $urandom_range(0, 7) == 0 ? MODN - 1 : $urandom_range(0, MODN - 1),
              $urandom_range(0, 1), $urandom_range(0, 3) == 0,
              $urandom_range(0, 1), $urandom_range(0, 1));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
